// File: rtl/vga_pkg.sv
// Shared types and constants for the background pattern stage of the VGA
// pipeline: the background mode encoding, the signature bitmap and a small
// checkerboard helper.
package vga_pkg;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        CHECKER = 2'd1,
        HGRAD   = 2'd2,
        SCROLL  = 2'd3
    } bg_mode_t;

    localparam int SIG_ROWS = 8;
    localparam int SIG_COLS = 16;

    // Row r lives at SIG_BITMAP[r]; bit c of a row is screen column c.
    localparam logic [SIG_ROWS-1:0][SIG_COLS-1:0] SIG_BITMAP = {
        16'h0000,   // row 7
        16'h0000,   // row 6
        16'h1D10,   // row 5
        16'h11B0,   // row 4
        16'h1D50,   // row 3
        16'h0550,   // row 2
        16'h1D10,   // row 1
        16'h0910    // row 0
    };

    // Parity of the tile indices: (x >> n) ^ (y >> n) equals (x ^ y) >> n,
    // and only its lowest bit decides which checker colour is shown.
    function automatic logic tile_parity(input logic [10:0] x,
                                         input logic [10:0] y,
                                         input int unsigned tile_log2);
        return |(((x ^ y) >> tile_log2) & 11'd1);
    endfunction

endpackage

// File: rtl/draw_bg_pattern_if.sv
// VGA bus carried between pipeline stages: timing counters, sync/blank
// strobes and the 12-bit pixel colour.
interface draw_bg_pattern_if;

    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (
        output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb
    );

    modport slave (
        input vcount, hcount, vsync, vblnk, hsync, hblnk, rgb
    );

endinterface

// File: rtl/sig_rom.sv
// Registered lookup of the signature bitmap. A whole row comes out one cycle
// after its index is presented; the column bit is picked downstream.
module sig_rom
    import vga_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(SIG_ROWS)-1:0] row,
    output logic [SIG_COLS-1:0]         row_data
);

    // Fetch the addressed bitmap row into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_data <= '0;
        end else begin
            row_data <= SIG_BITMAP[row];
        end
    end

endmodule

// File: rtl/draw_bg_pattern.sv
// Background generator: renders one of four patterns behind a scalable
// signature bitmap. Mode requests are acknowledged at once but only take
// effect at the next frame start, so a frame is never drawn in two modes.
// Two register stages sit between the timing inputs and bus_out.
module draw_bg_pattern
    import vga_pkg::*;
#(
    parameter logic [11:0] BG_COLOR       = 12'h222,
    parameter logic [11:0] ALT_COLOR      = 12'h444,
    parameter logic [11:0] SIG_COLOR      = 12'hfff,
    parameter int unsigned SIG_X          = 0,
    parameter int unsigned SIG_Y          = 0,
    parameter int unsigned SIG_SCALE_LOG2 = 0,
    parameter int unsigned TILE_LOG2      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       vcount_in,
    input  logic [10:0]       hcount_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic [1:0]        mode_in,
    input  logic              mode_req,
    output logic              mode_ack,
    input  logic              sig_en,
    draw_bg_pattern_if.master bus_out
);

    bg_mode_t    pending_mode;
    bg_mode_t    active_mode;
    bg_mode_t    render_mode;
    logic [7:0]  frame_cnt;
    logic [7:0]  render_cnt;
    logic        frame_start;

    logic [10:0] scroll_x;
    logic [11:0] pattern_rgb;

    logic [11:0] sig_dx;
    logic [11:0] sig_dy;
    logic [10:0] sig_col_full;
    logic [10:0] sig_row_full;
    logic        sig_window;
    logic [2:0]  sig_row;
    logic [15:0] sig_row_data;

    logic [10:0] s1_vcount;
    logic [10:0] s1_hcount;
    logic        s1_vsync;
    logic        s1_vblnk;
    logic        s1_hsync;
    logic        s1_hblnk;
    logic        s1_blank;
    logic [11:0] s1_pattern;
    logic [3:0]  s1_col;
    logic        s1_sig_win;

    assign frame_start = (vcount_in == 11'd0) && (hcount_in == 11'd0);

    // Accept mode requests, acknowledge them next cycle, and switch the
    // active mode and advance the frame counter on every frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_ack     <= 1'b0;
            pending_mode <= SOLID;
            active_mode  <= SOLID;
            frame_cnt    <= 8'd0;
        end else begin
            mode_ack <= mode_req;
            if (mode_req) begin
                pending_mode <= bg_mode_t'(mode_in);
            end
            if (frame_start) begin
                active_mode <= pending_mode;
                frame_cnt   <= frame_cnt + 8'd1;
            end
        end
    end

    // Pixel (0,0) is drawn with the values that its own edge is loading, so
    // the new mode and frame count already apply to the frame-start pixel.
    always_comb begin
        render_mode = active_mode;
        render_cnt  = frame_cnt;
        if (frame_start) begin
            render_mode = pending_mode;
            render_cnt  = frame_cnt + 8'd1;
        end
    end

    assign scroll_x = hcount_in + {3'b000, render_cnt};

    // Select the background colour for the current pixel.
    always_comb begin
        pattern_rgb = BG_COLOR;
        case (render_mode)
            SOLID: begin
                pattern_rgb = BG_COLOR;
            end
            CHECKER: begin
                if (tile_parity(hcount_in, vcount_in, TILE_LOG2)) begin
                    pattern_rgb = ALT_COLOR;
                end
            end
            HGRAD: begin
                pattern_rgb = {3{hcount_in[9:6]}};
            end
            SCROLL: begin
                if (tile_parity(scroll_x, vcount_in, TILE_LOG2)) begin
                    pattern_rgb = ALT_COLOR;
                end
            end
            default: begin
                pattern_rgb = BG_COLOR;
            end
        endcase
    end

    // The subtraction is one bit wider than the counters so that its top bit
    // flags pixels left of / above the signature origin.
    assign sig_dx       = {1'b0, hcount_in} - 12'(SIG_X);
    assign sig_dy       = {1'b0, vcount_in} - 12'(SIG_Y);
    assign sig_col_full = sig_dx[10:0] >> SIG_SCALE_LOG2;
    assign sig_row_full = sig_dy[10:0] >> SIG_SCALE_LOG2;
    assign sig_row      = sig_row_full[2:0];

    assign sig_window = sig_en
                      && !sig_dx[11]
                      && !sig_dy[11]
                      && (sig_col_full < 11'(SIG_COLS))
                      && (sig_row_full < 11'(SIG_ROWS));

    sig_rom u_sig_rom (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (sig_row),
        .row_data (sig_row_data)
    );

    // Stage 1: capture the pattern colour, signature window/column, blank
    // flag and delayed timing, alongside the ROM row fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vcount  <= 11'd0;
            s1_hcount  <= 11'd0;
            s1_vsync   <= 1'b0;
            s1_vblnk   <= 1'b0;
            s1_hsync   <= 1'b0;
            s1_hblnk   <= 1'b0;
            s1_blank   <= 1'b0;
            s1_pattern <= 12'h000;
            s1_col     <= 4'd0;
            s1_sig_win <= 1'b0;
        end else begin
            s1_vcount  <= vcount_in;
            s1_hcount  <= hcount_in;
            s1_vsync   <= vsync_in;
            s1_vblnk   <= vblnk_in;
            s1_hsync   <= hsync_in;
            s1_hblnk   <= hblnk_in;
            s1_blank   <= vblnk_in | hblnk_in;
            s1_pattern <= pattern_rgb;
            s1_col     <= sig_col_full[3:0];
            s1_sig_win <= sig_window;
        end
    end

    // Stage 2: blanking beats the signature, which beats the pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_out.vcount <= 11'd0;
            bus_out.hcount <= 11'd0;
            bus_out.vsync  <= 1'b0;
            bus_out.vblnk  <= 1'b0;
            bus_out.hsync  <= 1'b0;
            bus_out.hblnk  <= 1'b0;
            bus_out.rgb    <= 12'h000;
        end else begin
            bus_out.vcount <= s1_vcount;
            bus_out.hcount <= s1_hcount;
            bus_out.vsync  <= s1_vsync;
            bus_out.vblnk  <= s1_vblnk;
            bus_out.hsync  <= s1_hsync;
            bus_out.hblnk  <= s1_hblnk;
            if (s1_blank) begin
                bus_out.rgb <= 12'h000;
            end else if (s1_sig_win && sig_row_data[s1_col]) begin
                bus_out.rgb <= SIG_COLOR;
            end else begin
                bus_out.rgb <= s1_pattern;
            end
        end
    end

endmodule
